// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage with statistics counters.
// SKID_EN=1 gives a 2-entry main+skid buffer whose in_ready is a pure
// register decode, breaking the ready path between neighbouring stages.
// SKID_EN=0 gives a 1-entry stage whose in_ready passes out_ready through.
// occupancy, stall_cnt and xfer_cnt expose fill level and flow statistics.
module pipe_stage_buf #(
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  xfer_cnt
);

  // Encoding doubles as the occupancy value (0, 1 or 2 held entries).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   xfer_q, xfer_d;
  logic               out_stall;
  logic               out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;
  assign xfer_cnt  = xfer_q;

  assign out_stall = out_valid & ~out_ready;
  assign out_xfer  = out_valid & out_ready;

  // in_ready: registered decode in skid mode, pass-through in 1-entry mode.
  generate
    if (SKID_EN != 0) begin : g_skid_ready
      assign in_ready = (state_q != FULL);
    end else begin : g_pass_ready
      assign in_ready = ~out_valid | out_ready;
    end
  endgenerate

  // Next-state and data-load decode; flush overrides every transition and
  // leaves the data registers untouched.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (SKID_EN != 0) begin
            if (in_valid && out_ready) begin
              main_d = in_data;
            end else if (in_valid) begin
              skid_d  = in_data;
              state_d = FULL;
            end else if (out_ready) begin
              state_d = EMPTY;
            end
          end else begin
            if (out_ready) begin
              if (in_valid) main_d = in_data;
              else          state_d = EMPTY;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Saturating statistics counters; clr_cnt wins over increment, flush is
  // deliberately ignored here.
  always_comb begin
    stall_d = stall_q;
    xfer_d  = xfer_q;
    if (clr_cnt) begin
      stall_d = '0;
      xfer_d  = '0;
    end else begin
      if (out_stall && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_ONE;
      if (out_xfer  && (xfer_q  != CNT_MAX)) xfer_d  = xfer_q  + CNT_ONE;
    end
  end

  // FSM state register; reset empties the stage immediately.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Payload registers; they only change on an accepted beat or FULL->ONE shift.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the payload registers are reset because out_data must read 0
    // during reset; without that requirement they could stay unreset.
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      stall_q <= stall_d;
      xfer_q  <= xfer_d;
    end
  end

endmodule
